// File: rtl/pll_phase_pkg.sv
// Shared types, select encodings and default timing for the PLL dynamic phase-step sequencer.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_OUT0    = 2'b00;
    localparam logic [1:0] SEL_OUT2    = 2'b10;
    localparam logic [1:0] SEL_OUT3    = 2'b11;
    localparam logic [1:0] SEL_ILLEGAL = 2'b01;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 1;
    localparam int DEF_GAP_CYC   = 2;
    localparam int DEF_STEP_W    = 8;
    localparam int DEF_POS_W     = 8;

    localparam int NUM_OUTS = 3;

    // Position slot index (0,1,2) to the request select code of OUT0/OUT2/OUT3.
    function automatic logic [1:0] out_sel_code(input int idx);
        case (idx)
            0:       return SEL_OUT0;
            1:       return SEL_OUT2;
            default: return SEL_OUT3;
        endcase
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the CCC lock signal; clears to "unlocked" on reset.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Turns one-shot phase-step requests into the PF_CCC dynamic phase-shift pin protocol.
// Define PLL_PHASE_POS_TRACK_EN to implement the POS0/POS2/POS3 position counters.
module pll_phase_step_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic              CLK,
    input  logic              ARST_N,
    input  logic              PLL_LOCK,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_SEL,
    input  logic              REQ_DIR,
    input  logic [STEP_W-1:0] REQ_STEPS,
    output logic              RSP_VALID,
    output logic              RSP_ERR,
    output logic              BUSY,
    output logic              PHASE_OUT0_SEL,
    output logic              PHASE_OUT2_SEL,
    output logic              PHASE_OUT3_SEL,
    output logic              PHASE_DIRECTION,
    output logic              PHASE_ROTATE,
    output logic              LOAD_PHASE_N,
    output logic [POS_W-1:0]  POS0,
    output logic [POS_W-1:0]  POS2,
    output logic [POS_W-1:0]  POS3
);

    localparam int CYC_MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CYC_MAX    = (CYC_MAX_SP > GAP_CYC) ? CYC_MAX_SP : GAP_CYC;
    localparam int CNT_W      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] done_q, done_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;
    logic              lock_s;
    logic              req_ready;
    logic              sel_active;

    pll_lock_sync u_lock_sync (
        .clk      (CLK),
        .rst_n    (ARST_N),
        .async_in (PLL_LOCK),
        .sync_out (lock_s)
    );

    assign req_ready = (state_q == ST_IDLE) && lock_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        done_d  = done_q;
        steps_d = steps_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (REQ_VALID && req_ready) begin
                    sel_d   = REQ_SEL;
                    dir_d   = REQ_DIR;
                    steps_d = REQ_STEPS;
                    done_d  = '0;
                    err_d   = (REQ_SEL == SEL_ILLEGAL);
                    if (REQ_SEL == SEL_ILLEGAL || REQ_STEPS == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (!lock_s) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (!lock_s) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    // A pulse only counts if ROTATE was actually high for some cycle of it.
                    if (cnt_q != '0) begin
                        done_d = done_q + STEP_W'(1);
                    end
                end else if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                    cnt_d   = '0;
                    done_d  = done_q + STEP_W'(1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!lock_s) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (done_q < steps_q) ? ST_PULSE : ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= '0;
            steps_q <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            steps_q <= steps_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Select and direction are held from SETUP through LOAD so the PLL latches a stable target.
    assign sel_active      = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                             (state_q == ST_GAP)   || (state_q == ST_LOAD);
    assign PHASE_OUT0_SEL  = sel_active && (sel_q == SEL_OUT0);
    assign PHASE_OUT2_SEL  = sel_active && (sel_q == SEL_OUT2);
    assign PHASE_OUT3_SEL  = sel_active && (sel_q == SEL_OUT3);
    assign PHASE_DIRECTION = sel_active && dir_q;
    assign PHASE_ROTATE    = (state_q == ST_PULSE) && lock_s;
    assign LOAD_PHASE_N    = (state_q != ST_LOAD);
    assign REQ_READY       = req_ready;
    assign RSP_VALID       = (state_q == ST_DONE);
    assign RSP_ERR         = (state_q == ST_DONE) && err_q;
    assign BUSY            = (state_q != ST_IDLE);

`ifdef PLL_PHASE_POS_TRACK_EN
    logic [POS_W-1:0] pos_vec [NUM_OUTS];
    logic [POS_W-1:0] done_pos;

    assign done_pos = POS_W'(done_q);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTS; gi++) begin : g_pos
            logic [POS_W-1:0] pos_q, pos_d;

            always_comb begin
                pos_d = pos_q;
                if (state_q == ST_DONE && sel_q == out_sel_code(gi)) begin
                    pos_d = dir_q ? (pos_q + done_pos) : (pos_q - done_pos);
                end
            end

            always_ff @(posedge CLK or negedge ARST_N) begin
                if (!ARST_N) begin
                    pos_q <= '0;
                end else begin
                    pos_q <= pos_d;
                end
            end

            assign pos_vec[gi] = pos_q;
        end
    endgenerate

    assign POS0 = pos_vec[0];
    assign POS2 = pos_vec[1];
    assign POS3 = pos_vec[2];
`else
    assign POS0 = '0;
    assign POS2 = '0;
    assign POS3 = '0;
`endif

endmodule
